// File: rtl/vz_image_loader_pkg.sv
// Shared constants and state encoding for the VZ snapshot image loader.
package vz_image_loader_pkg;

  localparam int         VZ_HDR_LEN    = 24;
  localparam logic [7:0] VZ_TYPE_BASIC = 8'hF0;
  localparam logic [7:0] VZ_TYPE_MCODE = 8'hF1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DRAIN,
    ST_PATCH_LO,
    ST_PATCH_HI,
    ST_FIN,
    ST_ERR
  } vz_state_t;

  // Header magic "VZF0", indexed by file offset 0-3.
  function automatic logic [7:0] vz_magic(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h56;
      2'd1:    return 8'h5A;
      2'd2:    return 8'h46;
      default: return 8'h30;
    endcase
  endfunction

endpackage

// File: rtl/vz_image_loader_if.sv
// RAM write port: request/acknowledge handshake carrying one byte per accepted write.
interface vz_image_loader_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_req;
  logic              mem_ack;

  modport master (output mem_addr, output mem_data, output mem_req, input mem_ack);
  modport slave  (input mem_addr, input mem_data, input mem_req, output mem_ack);
endinterface

// File: rtl/vz_image_loader_sync_fifo.sv
// Single-clock FIFO with synchronous flush; push while full is dropped unless a pop frees a slot.
module vz_image_loader_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vz_image_loader.sv
// VZ snapshot loader: validates the header arriving on the download channel, buffers the
// payload and writes it to RAM, then patches the BASIC end pointer for type F0 images.
module vz_image_loader
  import vz_image_loader_pkg::*;
#(
  parameter int                ADDR_W       = 16,
  parameter int                FIFO_DEPTH   = 8,
  parameter logic [7:0]        DN_INDEX     = 8'd1,
  parameter logic [ADDR_W-1:0] END_PTR_ADDR = ADDR_W'(16'h78F9),
  parameter int                HDR_LEN      = VZ_HDR_LEN
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [15:0]       dn_addr,
  input  logic [7:0]        dn_data,
  input  logic [7:0]        dn_index,
  vz_image_loader_if.master mem,
  output logic [7:0]        img_type,
  output logic [ADDR_W-1:0] exec_addr,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  vz_state_t         state_q, state_d;
  logic              dl_q, idx_ok, dl_rise, dl_fall, byte_ok;
  logic [15:0]       exp_off;
  logic [ADDR_W:0]   in_addr;
  logic [ADDR_W-1:0] out_addr, exec_d, addr_q, patch_addr;
  logic [7:0]        type_d, data_q, patch_byte, fifo_dout;
  logic              req_q, req_data_q, error_q, launch_data, launch_patch;
  logic              push, pop, fifo_flush, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign idx_ok     = dn_index == DN_INDEX;
  assign dl_rise    = dn_download && !dl_q && idx_ok;
  assign dl_fall    = !dn_download && dl_q;
  assign byte_ok    = dn_wr && idx_ok;
  assign pop        = req_q && mem.mem_ack && req_data_q && !fifo_empty;
  assign fifo_flush = state_q == ST_ERR;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_data = data_q;
  assign busy         = state_q != ST_IDLE;
  assign done         = state_q == ST_FIN;
  assign error        = error_q;

  vz_image_loader_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .flush   (fifo_flush),
    .push    (push),
    .pop     (pop),
    .din     (dn_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Payload writes use the FIFO head; the two pointer-patch writes are launched from their own states.
  always_comb begin
    state_d      = state_q;
    push         = 1'b0;
    exec_d       = exec_addr;
    type_d       = img_type;
    launch_data  = 1'b0;
    launch_patch = 1'b0;
    patch_addr   = END_PTR_ADDR;
    patch_byte   = out_addr[7:0];
    case (state_q)
      ST_IDLE: if (dl_rise) state_d = ST_HDR;
      ST_HDR: begin
        if (byte_ok) begin
          if (dn_addr < 16'd4 && dn_data != vz_magic(dn_addr[1:0])) begin
            state_d = ST_ERR;
          end else begin
            if (dn_addr == 16'd21) type_d = dn_data;
            if (dn_addr == 16'd22) exec_d[7:0] = dn_data;
            if (dn_addr == 16'd23) exec_d[15:8] = dn_data;
            if (dn_addr == 16'(HDR_LEN - 1)) state_d = ST_DATA;
          end
        end else if (dl_fall) begin
          state_d = ST_ERR;
        end
      end
      ST_DATA: begin
        launch_data = !req_q && !fifo_empty;
        if (byte_ok) begin
          if (dn_addr != exp_off || in_addr[ADDR_W] || (fifo_full && !pop)) begin
            state_d = ST_ERR;
          end else begin
            push = 1'b1;
            if (dl_fall) state_d = ST_DRAIN;
          end
        end else if (dl_fall) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        launch_data = !req_q && !fifo_empty;
        if (fifo_count == '0 && !req_q)
          state_d = (img_type == VZ_TYPE_BASIC) ? ST_PATCH_LO : ST_FIN;
      end
      ST_PATCH_LO: begin
        launch_patch = !req_q;
        if (req_q && mem.mem_ack) state_d = ST_PATCH_HI;
      end
      ST_PATCH_HI: begin
        launch_patch = !req_q;
        patch_addr   = END_PTR_ADDR + ADDR_W'(1);
        patch_byte   = out_addr[15:8];
        if (req_q && mem.mem_ack) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      ST_ERR:  if (!dn_download) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q       <= 1'b0;
      error_q    <= 1'b0;
      img_type   <= '0;
      exec_addr  <= '0;
      exp_off    <= '0;
      in_addr    <= '0;
      out_addr   <= '0;
      req_q      <= 1'b0;
      req_data_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      dl_q <= dn_download;
      if (state_q == ST_IDLE && dl_rise) error_q <= 1'b0;
      else if (state_d == ST_ERR)        error_q <= 1'b1;
      if (state_q == ST_HDR) begin
        img_type  <= type_d;
        exec_addr <= exec_d;
      end
      // in_addr carries an extra bit so a byte past the top of RAM is caught before it is queued.
      if (state_q == ST_HDR && state_d == ST_DATA) begin
        exp_off  <= 16'(HDR_LEN);
        in_addr  <= {1'b0, exec_d};
        out_addr <= exec_d;
      end else begin
        if (push) begin
          exp_off <= exp_off + 16'd1;
          in_addr <= in_addr + (ADDR_W+1)'(1);
        end
        if (pop) out_addr <= out_addr + ADDR_W'(1);
      end
      if (req_q && mem.mem_ack) begin
        req_q      <= 1'b0;
        req_data_q <= 1'b0;
      end else if (launch_data) begin
        req_q      <= 1'b1;
        req_data_q <= 1'b1;
        addr_q     <= out_addr;
        data_q     <= fifo_dout;
      end else if (launch_patch) begin
        req_q  <= 1'b1;
        addr_q <= patch_addr;
        data_q <= patch_byte;
      end
    end
  end

endmodule

// File: tb/tb_vz_image_loader.sv
// Directed bench for the VZ image loader: streams headers and payloads over the download
// channel, answers the RAM port, and checks the write log and status flags.
module tb_vz_image_loader;
  import vz_image_loader_pkg::*;

  logic        clk_sys     = 1'b0;
  logic        reset       = 1'b1;
  logic        dn_download = 1'b0;
  logic        dn_wr       = 1'b0;
  logic [15:0] dn_addr     = '0;
  logic [7:0]  dn_data     = '0;
  logic [7:0]  dn_index    = 8'd1;
  logic [7:0]  img_type;
  logic [15:0] exec_addr;
  logic        busy, done, error;

  int   check_count = 0;
  int   pass_count  = 0;
  int   done_count  = 0;
  int   req_rises   = 0;
  logic req_prev    = 1'b0;
  bit   ack_enable  = 1'b1;
  int   ack_delay   = 0;
  int   wait_cnt    = 0;
  logic [15:0] log_addr [16];
  logic [7:0]  log_data [16];
  int   log_n = 0;

  vz_image_loader_if #(.ADDR_W(16)) bus ();

  vz_image_loader dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .dn_download (dn_download),
    .dn_wr       (dn_wr),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .dn_index    (dn_index),
    .mem         (bus),
    .img_type    (img_type),
    .exec_addr   (exec_addr),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM model: acknowledges a held request after ack_delay idle cycles and logs the write.
  always @(negedge clk_sys) begin
    if (reset) begin
      bus.mem_ack = 1'b0;
      wait_cnt    = 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
    end else if (bus.mem_req === 1'b1 && ack_enable) begin
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack = 1'b1;
        wait_cnt    = 0;
        if (log_n < 16) begin
          log_addr[log_n] = bus.mem_addr;
          log_data[log_n] = bus.mem_data;
        end
        log_n++;
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(negedge clk_sys) begin
    if (done === 1'b1) done_count++;
    if (bus.mem_req === 1'b1 && req_prev !== 1'b1) req_rises++;
    req_prev = bus.mem_req;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic checkWrite(input string tag, input int i, input logic [15:0] a, input logic [7:0] d);
    checkOutput(tag, {8'h00, log_addr[i], log_data[i]}, {8'h00, a, d});
  endtask

  task automatic clearLog();
    for (int i = 0; i < 16; i++) begin
      log_addr[i] = 'x;
      log_data[i] = 'x;
    end
    log_n      = 0;
    done_count = 0;
    req_rises  = 0;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input int gap);
    dn_addr = a;
    dn_data = d;
    dn_wr   = 1'b1;
    tick(1);
    dn_wr = 1'b0;
    tick(gap);
  endtask

  task automatic sendHeader(input logic [7:0] typ, input logic [15:0] start, input logic [7:0] m3, input int gap);
    logic [7:0] b;
    for (int i = 0; i < 24; i++) begin
      case (i)
        0, 1, 2: b = vz_magic(2'(i));
        3:       b = m3;
        21:      b = typ;
        22:      b = start[7:0];
        23:      b = start[15:8];
        default: b = 8'h00;
      endcase
      applyStimulus(16'(i), b, gap);
    end
  endtask

  task automatic startDownload(input logic [7:0] idx);
    dn_index    = idx;
    dn_download = 1'b1;
    tick(2);
  endtask

  task automatic endDownload();
    dn_download = 1'b0;
    tick(2);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    tick(3);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    checkOutput("reset_req", 32'(bus.mem_req), 32'd0);
    checkOutput("reset_img_type", 32'(img_type), 32'd0);
    reset = 1'b0;
    tick(2);

    // BASIC image, immediate acks, end pointer 7AEC patched at 78F9/78FA
    clearLog();
    ack_enable = 1'b1;
    ack_delay  = 0;
    startDownload(8'd1);
    sendHeader(VZ_TYPE_BASIC, 16'h7AE9, 8'h30, 0);
    applyStimulus(16'd24, 8'h11, 3);
    applyStimulus(16'd25, 8'h22, 3);
    applyStimulus(16'd26, 8'h33, 3);
    endDownload();
    waitIdle("basic_idle", 200);
    checkOutput("basic_write_count", 32'(log_n), 32'd5);
    checkWrite("basic_w0", 0, 16'h7AE9, 8'h11);
    checkWrite("basic_w1", 1, 16'h7AEA, 8'h22);
    checkWrite("basic_w2", 2, 16'h7AEB, 8'h33);
    checkWrite("basic_patch_lo", 3, 16'h78F9, 8'hEC);
    checkWrite("basic_patch_hi", 4, 16'h78FA, 8'h7A);
    checkOutput("basic_done_pulses", 32'(done_count), 32'd1);
    checkOutput("basic_img_type", 32'(img_type), 32'hF0);
    checkOutput("basic_exec_addr", 32'(exec_addr), 32'h7AE9);
    checkOutput("basic_error", 32'(error), 32'd0);

    // Machine-code image, bytes back to back, each ack delayed 5 cycles
    clearLog();
    ack_delay = 5;
    startDownload(8'd1);
    sendHeader(VZ_TYPE_MCODE, 16'h8000, 8'h30, 0);
    for (int k = 0; k < 4; k++) applyStimulus(16'(24 + k), 8'(8'hA1 + k), 0);
    endDownload();
    waitIdle("mcode_idle", 400);
    checkOutput("mcode_write_count", 32'(log_n), 32'd4);
    checkWrite("mcode_w0", 0, 16'h8000, 8'hA1);
    checkWrite("mcode_w1", 1, 16'h8001, 8'hA2);
    checkWrite("mcode_w2", 2, 16'h8002, 8'hA3);
    checkWrite("mcode_w3", 3, 16'h8003, 8'hA4);
    checkOutput("mcode_done_pulses", 32'(done_count), 32'd1);
    checkOutput("mcode_error", 32'(error), 32'd0);
    checkOutput("mcode_img_type", 32'(img_type), 32'hF1);

    // Bad magic byte 3, then a clean download clears the error
    clearLog();
    ack_delay = 0;
    startDownload(8'd1);
    sendHeader(VZ_TYPE_BASIC, 16'h7AE9, 8'h31, 0);
    checkOutput("magic_error", 32'(error), 32'd1);
    checkOutput("magic_busy_held", 32'(busy), 32'd1);
    checkOutput("magic_no_req", 32'(req_rises), 32'd0);
    endDownload();
    checkOutput("magic_idle", 32'(busy), 32'd0);
    checkOutput("magic_sticky", 32'(error), 32'd1);
    clearLog();
    startDownload(8'd1);
    checkOutput("magic_cleared", 32'(error), 32'd0);
    sendHeader(VZ_TYPE_MCODE, 16'h9000, 8'h30, 0);
    applyStimulus(16'd24, 8'h5A, 3);
    endDownload();
    waitIdle("recover_idle", 200);
    checkOutput("recover_done", 32'(done_count), 32'd1);
    checkWrite("recover_w0", 0, 16'h9000, 8'h5A);

    // FIFO overflow: no acks, ninth back-to-back payload byte errors out
    clearLog();
    ack_enable = 1'b0;
    startDownload(8'd1);
    sendHeader(VZ_TYPE_MCODE, 16'h9100, 8'h30, 0);
    for (int k = 0; k < 9; k++) applyStimulus(16'(24 + k), 8'(8'h40 + k), 0);
    checkOutput("ovf_error", 32'(error), 32'd1);
    checkOutput("ovf_req_rises", 32'(req_rises), 32'd1);
    checkOutput("ovf_req_pending", 32'(bus.mem_req), 32'd1);
    checkOutput("ovf_pending_addr", 32'(bus.mem_addr), 32'h9100);
    checkOutput("ovf_pending_data", 32'(bus.mem_data), 32'h40);
    endDownload();
    checkOutput("ovf_idle", 32'(busy), 32'd0);
    ack_enable = 1'b1;
    tick(6);
    checkOutput("ovf_write_count", 32'(log_n), 32'd1);
    checkOutput("ovf_no_new_req", 32'(req_rises), 32'd1);

    // Address wrap: FFFE and FFFF written, third byte errors, nothing at 0000
    clearLog();
    startDownload(8'd1);
    sendHeader(VZ_TYPE_MCODE, 16'hFFFE, 8'h30, 0);
    for (int k = 0; k < 3; k++) applyStimulus(16'(24 + k), 8'(8'hC1 + k), 4);
    checkOutput("wrap_error", 32'(error), 32'd1);
    endDownload();
    tick(4);
    checkOutput("wrap_write_count", 32'(log_n), 32'd2);
    checkWrite("wrap_w0", 0, 16'hFFFE, 8'hC1);
    checkWrite("wrap_w1", 1, 16'hFFFF, 8'hC2);
    checkOutput("wrap_no_done", 32'(done_count), 32'd0);

    // Asynchronous reset in the middle of the payload
    clearLog();
    ack_enable = 1'b0;
    startDownload(8'd1);
    sendHeader(VZ_TYPE_BASIC, 16'hA000, 8'h30, 0);
    applyStimulus(16'd24, 8'h77, 0);
    applyStimulus(16'd25, 8'h78, 2);
    checkOutput("rst_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_data", 32'(bus.mem_data), 32'd0);
    checkOutput("rst_img_type", 32'(img_type), 32'd0);
    checkOutput("rst_exec_addr", 32'(exec_addr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    dn_download = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);

    // Download on another menu index is ignored
    clearLog();
    ack_enable = 1'b1;
    ack_delay  = 0;
    startDownload(8'd2);
    checkOutput("idx_busy_start", 32'(busy), 32'd0);
    sendHeader(VZ_TYPE_MCODE, 16'h9000, 8'h30, 0);
    applyStimulus(16'd24, 8'h99, 2);
    checkOutput("idx_busy_data", 32'(busy), 32'd0);
    endDownload();
    tick(4);
    checkOutput("idx_no_req", 32'(req_rises), 32'd0);
    checkOutput("idx_no_write", 32'(log_n), 32'd0);
    checkOutput("idx_no_done", 32'(done_count), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/vz_image_loader.md
Name: vz_image_loader

Overview:
- Streams a downloaded VZ snapshot image (ioctl download channel) into system RAM through a handshaked write port.
- Parses and validates the 24-byte VZ header, extracts type and load address, buffers payload bytes in a FIFO, and patches the BASIC end-of-program pointer for BASIC images.
- Raises the core's `ready` or `error` status for LED and reset logic.
- Successor to the fixed single-slot loader: parametrised address width, FIFO depth, menu index and pointer location.

Parameters:
- ADDR_W, 16, RAM address width.
- FIFO_DEPTH, 8, payload buffer entries; power of two, ≥2.
- DN_INDEX, 1, ioctl index accepted as a VZ image.
- END_PTR_ADDR, 16'h78F9, little-endian BASIC end pointer, patched for type F0.
- HDR_LEN, 24, header bytes before payload.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dn_download  in  1  download active
- dn_wr  in  1  one-cycle byte strobe
- dn_addr  in  16  byte offset in file
- dn_data  in  8  file byte
- dn_index  in  8  menu slot index
- mem_addr  out  ADDR_W  RAM write address
- mem_data  out  8  RAM write data
- mem_req  out  1  write request, held until ack
- mem_ack  in  1  one-cycle write accept
- img_type  out  8  header type byte (F0 BASIC, F1 machine code)
- exec_addr  out  ADDR_W  header start address
- busy  out  1  loader active (drives LED)
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky until next accepted download start

Behaviour:
- Reset values: mem_req=0, mem_addr=0, mem_data=0, img_type=0, exec_addr=0, busy=0, done=0, error=0; FIFO empty; state IDLE.
- Bytes are accepted only when `dn_index==DN_INDEX`. Other indices are ignored entirely.
- States:
  - IDLE: on rising edge of dn_download with matching index, clear error and go to HDR.
  - HDR: offsets 0-3 must equal 56 5A 46 30 ("VZF0"); the first mismatch goes to ERR. Offset 21 latches img_type; offsets 22/23 latch exec_addr low/high. Offset HDR_LEN-1 goes to DATA.
  - DATA: each dn_wr pushes {dn_data} into the FIFO. Write address = exec_addr + (dn_addr − HDR_LEN), held in a running counter. On dn_download falling edge go to DRAIN.
  - DRAIN: wait for FIFO empty and no outstanding mem_req. If img_type==F0, go to PATCH_LO; otherwise go to FIN.
  - PATCH_LO / PATCH_HI: write end address (last written address + 1) low byte to END_PTR_ADDR, then high byte to END_PTR_ADDR+1, each via the handshake. Then go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
  - ERR: error=1, flush FIFO, abandon outstanding request after current ack, and ignore bytes until dn_download falls; then IDLE.
- Handshake:
  - mem_req rises the cycle after FIFO non-empty while idle on the port.
  - mem_addr and mem_data stay stable while mem_req=1.
  - On mem_ack: pop the FIFO; mem_req may re-assert the next cycle (one write per 2 cycles maximum).
  - mem_ack while mem_req=0 is ignored.
- The FIFO is needed because dn_wr may arrive faster than acks. A push while full goes to ERR (overflow). Push and pop in the same cycle is legal at any fill level except full-without-pop.
- Address wrap: a payload byte whose address would exceed 2^ADDR_W−1 goes to ERR; the byte is not written.
- A download ending inside HDR (fewer than HDR_LEN bytes) goes to ERR.
- Non-sequential dn_addr in DATA goes to ERR.
- busy=1 in every state except IDLE.
- Asynchronous reset mid-operation returns to reset values immediately. A partially written image is not rolled back.

Decomposition:
- Package vz_pkg: VZ magic bytes, VZ_TYPE_BASIC=8'hF0, VZ_TYPE_MCODE=8'hF1, HDR_LEN default, state enum.
- One sub-module: sync_fifo (width 8, depth FIFO_DEPTH, full/empty/count outputs), reusable elsewhere.

Test Plan:
- BASIC image, start 7AE9, 3 payload bytes 11 22 33, immediate ack → writes 7AE9=11, 7AEA=22, 7AEB=33. Then 78F9=EC, 78FA=7A. One done pulse; img_type=F0; exec_addr=7AE9.
- Machine-code image type F1, start 8000, 4 bytes, ack delayed 5 cycles each → writes to 8000-8003 in order, no pointer patch, done pulse, FIFO never overflows.
- Magic byte 3 = 31 → error=1 after offset 3, zero mem_req cycles, busy until dn_download falls; a following valid download clears error.
- Bytes on every cycle with mem_ack tied low, FIFO_DEPTH=8 → overflow on the 9th payload byte, error=1, no further writes issued after the pending one.
- Start FFFE with 3 payload bytes → FFFE and FFFF written, third byte raises error, no write to 0000.
- Reset asserted mid-DATA → all outputs at reset values the same cycle, state IDLE; mismatched dn_index download produces no activity.
